// File: rtl/text_console_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the text console write-side controller.
package text_console_pkg;

   localparam int unsigned COLS   = 80;
   localparam int unsigned ROWS   = 30;
   localparam int unsigned CELLS  = COLS * ROWS;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned COL_W  = 7;
   localparam int unsigned ROW_W  = 5;
   localparam int unsigned DATA_W = 8;

   localparam logic [DATA_W-1:0] FILL     = 8'h20;
   localparam logic [DATA_W-1:0] CH_BS    = 8'h08;
   localparam logic [DATA_W-1:0] CH_LF    = 8'h0A;
   localparam logic [DATA_W-1:0] CH_FF    = 8'h0C;
   localparam logic [DATA_W-1:0] CH_CR    = 8'h0D;
   localparam logic [DATA_W-1:0] PRINT_LO = 8'h20;
   localparam logic [DATA_W-1:0] PRINT_HI = 8'h7E;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CLR_LINE = 2'd1,
      CLR_ALL  = 2'd2
   } state_e;

   // One text-memory write beat.
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] din;
   } mem_wr_t;

   // row*80 as (row<<6)+(row<<4); at most 29*80 = 2320, fits in 12 bits.
   function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] row);
      return ADDR_W'({row, 6'b0}) + ADDR_W'({row, 4'b0});
   endfunction

endpackage

// File: rtl/text_console_ctrl_if.sv
// Byte-stream valid/ready channel feeding the text console.
interface text_console_if;
   import text_console_pkg::*;

   logic              ch_valid;
   logic [DATA_W-1:0] ch_data;
   logic              ch_ready;

   modport master (output ch_valid, output ch_data, input ch_ready);
   modport slave  (input ch_valid, input ch_data, output ch_ready);
endinterface

// File: rtl/text_clear_seq.sv
// Address sequencer for clear operations: walks base..base+len-1, one beat per cycle.
module text_clear_seq
   import text_console_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              run_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [ADDR_W-1:0] len_i,
   output logic              we_c,
   output logic [ADDR_W-1:0] addr_c,
   output logic              done_c
);

   logic [ADDR_W-1:0] cnt_q, cnt_d;

   // Beat generation and offset counter; the counter rewinds on start and on the last beat.
   always_comb begin
      we_c   = run_i;
      addr_c = base_i + cnt_q;
      done_c = run_i && (cnt_q == (len_i - ADDR_W'(1)));
      cnt_d  = cnt_q;
      if (start_i) begin
         cnt_d = '0;
      end else if (done_c) begin
         cnt_d = '0;
      end else if (run_i) begin
         cnt_d = cnt_q + ADDR_W'(1);
      end
   end

   // Offset register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/text_console_ctrl.sv
// Write-side controller for the 80x30 text memory: cursor tracking, character writes and clears.
module text_console_ctrl
   import text_console_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   text_console_if.slave     ch,
   input  logic              clear_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              busy,
   output logic [COL_W-1:0]  cursor_col,
   output logic [ROW_W-1:0]  cursor_row
);

   state_e            state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   mem_wr_t           wr_q, wr_d;

   logic              seq_start;
   logic              seq_we;
   logic              seq_done;
   logic [ADDR_W-1:0] seq_addr;
   logic [ADDR_W-1:0] seq_base;
   logic [ADDR_W-1:0] seq_len;
   logic              is_print;
   logic [ROW_W-1:0]  row_nxt;

   assign ch.ch_ready = (state_q == IDLE) && !clear_req;
   assign busy        = (state_q != IDLE);

   assign is_print = (ch.ch_data >= PRINT_LO) && (ch.ch_data <= PRINT_HI);
   assign row_nxt  = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);

   // A line clear targets the (already advanced) cursor row; a full clear starts at 0.
   assign seq_base = (state_q == CLR_LINE) ? row_base(row_q) : '0;
   assign seq_len  = (state_q == CLR_LINE) ? ADDR_W'(COLS) : ADDR_W'(CELLS);

   text_clear_seq u_clear_seq (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (seq_start),
      .run_i   (busy),
      .base_i  (seq_base),
      .len_i   (seq_len),
      .we_c    (seq_we),
      .addr_c  (seq_addr),
      .done_c  (seq_done)
   );

   // Next-state, cursor and write-port decode.
   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      wr_d      = wr_q;
      wr_d.we   = 1'b0;
      seq_start = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d   = CLR_ALL;
               col_d     = '0;
               row_d     = '0;
               seq_start = 1'b1;
            end else if (ch.ch_valid) begin
               if (is_print) begin
                  wr_d.we   = 1'b1;
                  wr_d.addr = row_base(row_q) + ADDR_W'(col_q);
                  wr_d.din  = ch.ch_data;
                  if (col_q == COL_LAST) begin
                     col_d     = '0;
                     row_d     = row_nxt;
                     state_d   = CLR_LINE;
                     seq_start = 1'b1;
                  end else begin
                     col_d = col_q + COL_W'(1);
                  end
               end else begin
                  case (ch.ch_data)
                     CH_LF: begin
                        col_d     = '0;
                        row_d     = row_nxt;
                        state_d   = CLR_LINE;
                        seq_start = 1'b1;
                     end
                     CH_CR: col_d = '0;
                     CH_BS: begin
                        if (col_q != '0) begin
                           col_d = col_q - COL_W'(1);
                        end
                     end
                     CH_FF: begin
                        state_d   = CLR_ALL;
                        col_d     = '0;
                        row_d     = '0;
                        seq_start = 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
         end
         CLR_LINE, CLR_ALL: begin
            wr_d.we   = seq_we;
            wr_d.addr = seq_addr;
            wr_d.din  = FILL;
            if (seq_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, cursor and write-port registers; reset lands in a full clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLR_ALL;
         col_q   <= '0;
         row_q   <= '0;
         wr_q    <= '{we: 1'b0, addr: '0, din: FILL};
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         wr_q    <= wr_d;
      end
   end

   assign mem_we     = wr_q.we;
   assign mem_addr   = wr_q.addr;
   assign mem_din    = wr_q.din;
   assign cursor_col = col_q;
   assign cursor_row = row_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Bench for text_console_ctrl: cycle model of the console rules plus directed scenarios.
module tb_text_console_ctrl;
   import text_console_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear_req = 1'b0;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [7:0]  mem_din;
   logic        busy;
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row;

   text_console_if cif ();

   text_console_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ch         (cif),
      .clear_req  (clear_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .busy       (busy),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row)
   );

   always #5 clk = ~clk;

   int vec_cnt = 0;
   int err_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Model state: mode 0 idle, 1 clearing a line, 2 clearing the screen.
   int   m_mode = 2;
   int   m_left = 2400;
   int   m_next = 0;
   int   m_col = 0;
   int   m_row = 0;
   bit   m_we = 1'b0;
   int   m_addr = 0;
   int   m_din = 8'h20;
   int   b;

   // Console rules applied once per clock edge from the sampled inputs.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 2; m_left = 2400; m_next = 0;
         m_col = 0; m_row = 0;
         m_we = 1'b0; m_addr = 0; m_din = 8'h20;
      end else begin
         m_we = 1'b0;
         if (m_mode != 0) begin
            m_we = 1'b1; m_addr = m_next; m_din = 8'h20;
            m_next++; m_left--;
            if (m_left == 0) m_mode = 0;
         end else if (clear_req) begin
            m_mode = 2; m_left = 2400; m_next = 0; m_col = 0; m_row = 0;
         end else if (cif.ch_valid) begin
            b = int'(cif.ch_data);
            if (b >= 32 && b <= 126) begin
               m_we = 1'b1; m_addr = m_row * 80 + m_col; m_din = b;
               if (m_col == 79) begin
                  m_col = 0; m_row = (m_row + 1) % 30;
                  m_mode = 1; m_left = 80; m_next = m_row * 80;
               end else begin
                  m_col++;
               end
            end else if (b == 10) begin
               m_col = 0; m_row = (m_row + 1) % 30;
               m_mode = 1; m_left = 80; m_next = m_row * 80;
            end else if (b == 13) begin
               m_col = 0;
            end else if (b == 8) begin
               if (m_col > 0) m_col--;
            end else if (b == 12) begin
               m_mode = 2; m_left = 2400; m_next = 0; m_col = 0; m_row = 0;
            end
         end
      end
   end

   int wr_total = 0;
   int last_waddr = -1;
   int prev_waddr = -1;
   int last_wdin = 0;
   int prev_wdin = 0;

   // Every-cycle comparison against the model, plus a log of observed writes.
   always @(negedge clk) begin
      check("busy", 32'(busy), 32'(m_mode != 0));
      check("ch_ready", 32'(cif.ch_ready), 32'(m_mode == 0 && !clear_req));
      check("mem_we", 32'(mem_we), 32'(m_we));
      check("cursor_col", 32'(cursor_col), 32'(m_col));
      check("cursor_row", 32'(cursor_row), 32'(m_row));
      if (m_we || !rst_n) begin
         check("mem_addr", 32'(mem_addr), 32'(m_addr));
         check("mem_din", 32'(mem_din), 32'(m_din));
      end
      if (mem_we === 1'b1) begin
         prev_waddr = last_waddr; prev_wdin = last_wdin;
         last_waddr = int'(mem_addr); last_wdin = int'(mem_din);
         wr_total++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (busy !== 1'b0 && k < budget) begin
         tick(1);
         k++;
      end
      check("wait_idle", 32'(busy), 32'd0);
   endtask

   task automatic send(input logic [7:0] c);
      int k = 0;
      cif.ch_valid = 1'b1;
      cif.ch_data  = c;
      while (cif.ch_ready !== 1'b1 && k < 3000) begin
         tick(1);
         k++;
      end
      check("send_ready", 32'(cif.ch_ready), 32'd1);
      tick(1);
      cif.ch_valid = 1'b0;
   endtask

   int w0;
   int bs_exp [4] = '{2, 1, 0, 0};

   initial begin
      cif.ch_valid = 1'b0;
      cif.ch_data  = 8'h00;
      tick(3);
      // Held in reset: registered port at reset values, full clear pending.
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_din", 32'(mem_din), 32'h20);
      check("rst_busy", 32'(busy), 32'd1);

      // Power-on clear.
      rst_n = 1'b1;
      w0 = wr_total;
      wait_idle(3000);
      tick(1);
      check("pon_writes", 32'(wr_total - w0), 32'd2400);
      check("pon_last_addr", 32'(last_waddr), 32'd2399);
      check("pon_ready", 32'(cif.ch_ready), 32'd1);
      check("pon_cursor", {20'd0, 5'(cursor_row), cursor_col}, 32'd0);

      // Back-to-back "AB".
      w0 = wr_total;
      cif.ch_valid = 1'b1; cif.ch_data = 8'h41;
      tick(1);
      cif.ch_data = 8'h42;
      tick(1);
      cif.ch_valid = 1'b0;
      tick(1);
      check("ab_writes", 32'(wr_total - w0), 32'd2);
      check("ab_first", 32'(prev_waddr * 256 + prev_wdin), 32'h41);
      check("ab_second", 32'(last_waddr * 256 + last_wdin), 32'h142);
      check("ab_col", 32'(cursor_col), 32'd2);

      // Full row of printables, then the automatic clear of row 1.
      send(CH_CR);
      tick(1);
      w0 = wr_total;
      cif.ch_valid = 1'b1;
      for (int i = 0; i < 80; i++) begin
         cif.ch_data = 8'(8'h30 + i % 10);
         tick(1);
      end
      cif.ch_valid = 1'b0;
      wait_idle(200);
      tick(1);
      check("row_writes", 32'(wr_total - w0), 32'd160);
      check("row_last_addr", 32'(last_waddr), 32'd159);
      check("row_last_din", 32'(last_wdin), 32'h20);
      check("row_cursor", {20'd0, 5'(cursor_row), cursor_col}, {20'd0, 5'd1, 7'd0});

      // Walk to row 29, column 5, then LF wraps to row 0 and clears it.
      for (int i = 0; i < 28; i++) send(CH_LF);
      for (int i = 0; i < 5; i++) send(8'h61);
      tick(1);
      check("pre_wrap_cursor", {20'd0, 5'(cursor_row), cursor_col}, {20'd0, 5'd29, 7'd5});
      w0 = wr_total;
      send(CH_LF);
      wait_idle(200);
      tick(1);
      check("wrap_writes", 32'(wr_total - w0), 32'd80);
      check("wrap_last_addr", 32'(last_waddr), 32'd79);
      check("wrap_cursor", {20'd0, 5'(cursor_row), cursor_col}, 32'd0);

      // Backspace clamps at column 0; CR and unknown codes write nothing.
      send(CH_LF);
      send(CH_LF);
      for (int i = 0; i < 3; i++) send(8'h78);
      tick(1);
      check("bs_start", {20'd0, 5'(cursor_row), cursor_col}, {20'd0, 5'd2, 7'd3});
      w0 = wr_total;
      for (int i = 0; i < 4; i++) begin
         send(CH_BS);
         check("bs_col", 32'(cursor_col), 32'(bs_exp[i]));
      end
      tick(1);
      check("bs_nowrite", 32'(wr_total - w0), 32'd0);
      send(8'h51);
      send(CH_CR);
      check("cr_col", 32'(cursor_col), 32'd0);
      tick(1);
      w0 = wr_total;
      send(8'h01);
      send(8'h7F);
      tick(1);
      check("unknown_nowrite", 32'(wr_total - w0), 32'd0);
      check("unknown_cursor", {20'd0, 5'(cursor_row), cursor_col}, {20'd0, 5'd2, 7'd0});

      // Form feed: full clear.
      w0 = wr_total;
      send(CH_FF);
      check("ff_busy", 32'(busy), 32'd1);
      wait_idle(3000);
      tick(1);
      check("ff_writes", 32'(wr_total - w0), 32'd2400);
      check("ff_last_addr", 32'(last_waddr), 32'd2399);
      check("ff_cursor", {20'd0, 5'(cursor_row), cursor_col}, 32'd0);

      // clear_req beats a simultaneous 'X'; reset lands mid-clear and it restarts.
      send(8'h5A);
      cif.ch_valid = 1'b1; cif.ch_data = 8'h58; clear_req = 1'b1;
      tick(1);
      check("req_busy", 32'(busy), 32'd1);
      check("req_cursor", {20'd0, 5'(cursor_row), cursor_col}, 32'd0);
      clear_req = 1'b0; cif.ch_valid = 1'b0;
      tick(500);
      check("mid_clear_we", 32'(mem_we), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_we", 32'(mem_we), 32'd0);
      check("abort_addr", 32'(mem_addr), 32'd0);
      check("abort_din", 32'(mem_din), 32'h20);
      tick(2);
      rst_n = 1'b1;
      w0 = wr_total;
      wait_idle(3000);
      tick(1);
      check("restart_writes", 32'(wr_total - w0), 32'd2400);
      check("restart_last_addr", 32'(last_waddr), 32'd2399);
      check("restart_ready", 32'(cif.ch_ready), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   // Global time bound.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/text_console_ctrl.md
Name: text_console_ctrl

Overview:
- Write-side controller for the 80x30 text memory.
- Takes a byte stream over a valid/ready handshake and tracks a cursor. Printable codes are written at the cursor address; control codes move the cursor or clear the screen.
- Drives the text memory's write port (we, addr, din). The display side keeps reading that memory through the other port.

Parameters:
- COLS, 80, characters per row.
- ROWS, 30, rows per screen; COLS*ROWS must be <= 4096.
- FILL, 8'h20, byte written by all clear operations.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- ch_valid  in  1  ch_data is valid.
- ch_data  in  8  character or control code.
- ch_ready  out  1  byte accepted on a rising edge where ch_valid && ch_ready.
- clear_req  in  1  level request to clear the screen and home the cursor.
- mem_we  out  1  text memory write enable.
- mem_addr  out  12  write address, row*COLS+col.
- mem_din  out  8  write data.
- busy  out  1  a clear operation is in progress.
- cursor_col  out  7  current column, 0..COLS-1.
- cursor_row  out  5  current row, 0..ROWS-1.

Behaviour:
- Reset (async, rst_n low):
  - mem_we=0, mem_addr=0, mem_din=FILL, cursor=(0,0), clear counter=0.
  - State = CLR_ALL, so a power-on full-screen clear runs as soon as rst_n rises.
  - Reset asserted mid-operation aborts it; the full clear restarts after release.
- Outputs: mem_we, mem_addr, mem_din and the cursor are registered. busy = (state != IDLE). ch_ready = (state == IDLE) && !clear_req.
- States: IDLE, CLR_LINE, CLR_ALL.
- IDLE, clear_req=1: enter CLR_ALL; ch_valid is ignored that cycle (clear_req has priority).
- IDLE, byte accepted. Handling by code (edge of acceptance = E):
  - 0x20..0x7E: at E, mem_we<=1, mem_addr<=row*COLS+col, mem_din<=byte, col<=col+1.
    - If col was COLS-1: col<=0, row<=(row==ROWS-1)?0:row+1, enter CLR_LINE for the new row.
    - Throughput: 1 char/cycle while no line change occurs.
  - 0x0A (LF): col<=0, row advances with the same wrap rule, enter CLR_LINE. No character write.
  - 0x0D (CR): col<=0. No write.
  - 0x08 (BS): col<=col-1 if col>0, else unchanged. No write; row never changes.
  - 0x0C (FF): enter CLR_ALL.
  - Any other code: consumed, no effect.
  - mem_we is 0 in every IDLE cycle without a printable accept.
- CLR_LINE:
  - Exactly COLS cycles with mem_we=1, mem_din=FILL, mem_addr=newrow*COLS+k, k=0..COLS-1.
  - Then IDLE. ch_ready=0 throughout.
  - The final printable write (E) occurs before the first clear write; they never collide because the row has changed.
- CLR_ALL:
  - COLS*ROWS cycles (2400) with mem_we=1, mem_din=FILL, mem_addr=0..2399 ascending.
  - Cursor is forced to (0,0) on entry.
  - Then IDLE. clear_req is not re-sampled during the clear.
  - clear_req still high on return to IDLE starts another clear; callers drop it once busy is seen.
- Address arithmetic: row*80 = (row<<6)+(row<<4); the result is 12 bits and never exceeds 2399.
- Wrap: after row ROWS-1 the cursor returns to row 0 and that row is cleared. There is no scrolling.

Decomposition:
- Package text_console_pkg:
  - COLS, ROWS, FILL.
  - Control-code constants CH_BS=8'h08, CH_LF=8'h0A, CH_FF=8'h0C, CH_CR=8'h0D, PRINT_LO=8'h20, PRINT_HI=8'h7E.
  - State enum {IDLE, CLR_LINE, CLR_ALL}.
- Sub-module text_clear_seq:
  - Inputs: start, base address, length (COLS or COLS*ROWS).
  - Outputs: sequential addresses with a we strobe and a done pulse.
  - The FSM starts it and waits for done.

Test Plan:
- Power-on: release rst_n → busy=1 and exactly 2400 writes (addr 0..2399, din 0x20), then busy=0, ch_ready=1, cursor=(0,0).
- Back-to-back "AB", ch_valid held 2 cycles → writes (0,'A'=0x41) then (1,0x42) on consecutive cycles; cursor_col=2.
- 80 printables from (0,0) → last write at addr 79, then 80 FILL writes at addr 80..159 with ch_ready=0; cursor=(0,1).
- Cursor (5,29), send 0x0A → no char write; CLR_LINE writes addr 0..79; cursor=(0,0).
- Cursor (3,2): send 0x08 ×4 → col 2,1,0,0 with no writes; send 0x0D → col 0.
- Send 0x0C, or raise clear_req in the same cycle as ch_valid with 'X' → 'X' not accepted, full 2400-cycle clear, cursor (0,0). Assert rst_n=0 mid-clear → outputs reset immediately and the clear restarts from addr 0 after release.
